// File: rtl/writeback_stage.sv
// Writeback stage: buffers ALU and load results in per-source FIFOs and drives
// the two register-file write ports, holding MEM back on same-address collisions.

module wb_fifo #(
    parameter int W     = 32,
    parameter int N     = 16,
    parameter int A     = $clog2(N),
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [A-1:0] push_addr,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         ready,
    output logic         head_vld,
    output logic [A-1:0] head_addr,
    output logic [W-1:0] head_data,
    output logic [N-1:0] mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A-1:0]  addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    // Ready looks only at the stored count so the pop side never feeds back.
    assign ready     = (count < CW'(DEPTH));
    assign head_vld  = (count != '0);
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PW-1:0] off;
        off  = '0;
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) mask[addr_q[i]] = 1'b1;
        end
    end
endmodule

module writeback_stage #(
    parameter int W     = 32,
    parameter int N     = 16,
    parameter int A     = $clog2(N),
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [A-1:0] alu_addr,
    input  logic [W-1:0] alu_data,
    input  logic         mem_valid,
    output logic         mem_ready,
    input  logic [A-1:0] mem_addr,
    input  logic [W-1:0] mem_data,
    output logic         wr_en1,
    output logic [A-1:0] wr_addr1,
    output logic [W-1:0] wr_data1,
    output logic         wr_en2,
    output logic [A-1:0] wr_addr2,
    output logic [W-1:0] wr_data2,
    output logic [N-1:0] pend_mask
);
    logic         alu_hv, mem_hv, alu_pop, mem_pop;
    logic [A-1:0] alu_ha, mem_ha;
    logic [W-1:0] alu_hd, mem_hd;
    logic [N-1:0] alu_mask, mem_mask;

    wb_fifo #(.W(W), .N(N), .A(A), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(alu_valid & alu_ready), .push_addr(alu_addr), .push_data(alu_data),
        .pop(alu_pop), .ready(alu_ready),
        .head_vld(alu_hv), .head_addr(alu_ha), .head_data(alu_hd), .mask(alu_mask)
    );

    wb_fifo #(.W(W), .N(N), .A(A), .DEPTH(DEPTH)) u_mem_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(mem_valid & mem_ready), .push_addr(mem_addr), .push_data(mem_data),
        .pop(mem_pop), .ready(mem_ready),
        .head_vld(mem_hv), .head_addr(mem_ha), .head_data(mem_hd), .mask(mem_mask)
    );

    // On an address collision ALU wins; MEM waits so the older ALU value is
    // never written after the load that follows it.
    assign alu_pop = alu_hv;
    assign mem_pop = mem_hv & ~(alu_hv & (alu_ha == mem_ha));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en1   <= 1'b0;
            wr_addr1 <= '0;
            wr_data1 <= '0;
            wr_en2   <= 1'b0;
            wr_addr2 <= '0;
            wr_data2 <= '0;
        end else begin
            wr_en1 <= alu_pop;
            wr_en2 <= mem_pop;
            if (alu_pop) begin
                wr_addr1 <= alu_ha;
                wr_data1 <= alu_hd;
            end
            if (mem_pop) begin
                wr_addr2 <= mem_ha;
                wr_data2 <= mem_hd;
            end
        end
    end

    always_comb begin
        pend_mask = alu_mask | mem_mask;
        if (wr_en1) pend_mask[wr_addr1] = 1'b1;
        if (wr_en2) pend_mask[wr_addr2] = 1'b1;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model.

module tb_writeback_stage;
    localparam int W = 32, N = 16, A = 4, DEPTH = 2;
    localparam int OW = 2 * (1 + A + W) + N + 2;

    typedef struct packed {
        logic [A-1:0] a;
        logic [W-1:0] d;
    } ent_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic alu_valid = 1'b0, mem_valid = 1'b0;
    logic [A-1:0] alu_addr = '0, mem_addr = '0;
    logic [W-1:0] alu_data = '0, mem_data = '0;
    logic alu_ready, mem_ready, wr_en1, wr_en2;
    logic [A-1:0] wr_addr1, wr_addr2;
    logic [W-1:0] wr_data1, wr_data2;
    logic [N-1:0] pend_mask;

    writeback_stage #(.W(W), .N(N), .A(A), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0, cyc = 0;

    // Reference model: queues of pending writes plus the expected port registers.
    ent_t aq[$], mq[$];
    logic e_en1, e_en2;
    logic [A-1:0] e_a1, e_a2;
    logic [W-1:0] e_d1, e_d2;
    bit last_acc_a, last_acc_m;

    task automatic model_reset();
        aq.delete(); mq.delete();
        e_en1 = 0; e_en2 = 0; e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
        last_acc_a = 0; last_acc_m = 0;
    endtask

    function automatic logic [N-1:0] model_pend();
        logic [N-1:0] m = '0;
        foreach (aq[i]) m[aq[i].a] = 1'b1;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        if (e_en1) m[e_a1] = 1'b1;
        if (e_en2) m[e_a2] = 1'b1;
        return m;
    endfunction

    function automatic logic [OW-1:0] dut_vec();
        return {wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2, pend_mask, alu_ready, mem_ready};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        return {e_en1, e_a1, e_d1, e_en2, e_a2, e_d2, model_pend(),
                1'(aq.size() < DEPTH), 1'(mq.size() < DEPTH)};
    endfunction

    // One clock edge: accept what the model says is accepted, retire heads, then sample at +1.
    task automatic tick();
        bit acc_a, acc_m, pa, pm;
        ent_t na, nm, h;
        acc_a = alu_valid && (aq.size() < DEPTH);
        acc_m = mem_valid && (mq.size() < DEPTH);
        na = '{alu_addr, alu_data};
        nm = '{mem_addr, mem_data};
        @(posedge clk);
        pa = aq.size() > 0;
        pm = (mq.size() > 0) && !(pa && aq[0].a == mq[0].a);
        e_en1 = pa; e_en2 = pm;
        if (pa) begin h = aq.pop_front(); e_a1 = h.a; e_d1 = h.d; end
        if (pm) begin h = mq.pop_front(); e_a2 = h.a; e_d2 = h.d; end
        if (acc_a) aq.push_back(na);
        if (acc_m) mq.push_back(nm);
        last_acc_a = acc_a; last_acc_m = acc_m;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if ({wr_en1, wr_en2, pend_mask, alu_ready, mem_ready} !== {2'b00, {N{1'b0}}, 2'b11}) begin
            errs++;
            $display("FAIL reset got en=%b%b pend=%h rdy=%b%b exp en=00 pend=0 rdy=11",
                     wr_en1, wr_en2, pend_mask, alu_ready, mem_ready);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_addr = 3; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        vectors++;
        if (pend_mask[3] !== 1'b1 || wr_en1 !== 1'b0) begin
            errs++; $display("FAIL alu_single_q got pend3=%b en1=%b exp 1 0", pend_mask[3], wr_en1);
        end
        tick();
        vectors++;
        if ({wr_en1, wr_addr1, wr_data1, pend_mask[3]} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b1}) begin
            errs++; $display("FAIL alu_single_out got en=%b a=%0d d=%h pend3=%b exp 1 3 deadbeef 1",
                             wr_en1, wr_addr1, wr_data1, pend_mask[3]);
        end
        tick();
        vectors++;
        if (wr_en1 !== 1'b0 || pend_mask !== '0) begin
            errs++; $display("FAIL alu_single_done got en1=%b pend=%h exp 0 0", wr_en1, pend_mask);
        end
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            errs++; $display("FAIL alu_single_model got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_parallel();
        alu_valid = 1; alu_addr = 5; alu_data = 32'h11;
        mem_valid = 1; mem_addr = 6; mem_data = 32'h22;
        tick();
        alu_valid = 0; mem_valid = 0;
        tick();
        vectors++;
        if ({wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2} !==
            {1'b1, 4'd5, 32'h11, 1'b1, 4'd6, 32'h22}) begin
            errs++; $display("FAIL parallel got %b/%0d/%h %b/%0d/%h exp 1/5/11 1/6/22",
                             wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
        end
        tick();
    endtask

    task automatic test_conflict();
        alu_valid = 1; alu_addr = 7; alu_data = 32'hAAAA;
        mem_valid = 1; mem_addr = 7; mem_data = 32'hBBBB;
        tick();
        alu_valid = 0; mem_valid = 0;
        tick();
        vectors++;
        if ({wr_en1, wr_addr1, wr_data1, wr_en2} !== {1'b1, 4'd7, 32'hAAAA, 1'b0}) begin
            errs++; $display("FAIL conflict_alu got en1=%b a=%0d d=%h en2=%b exp 1 7 aaaa 0",
                             wr_en1, wr_addr1, wr_data1, wr_en2);
        end
        tick();
        vectors++;
        if ({wr_en2, wr_addr2, wr_data2, wr_en1} !== {1'b1, 4'd7, 32'hBBBB, 1'b0}) begin
            errs++; $display("FAIL conflict_mem got en2=%b a=%0d d=%h en1=%b exp 1 7 bbbb 0",
                             wr_en2, wr_addr2, wr_data2, wr_en1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got[$];
        int k = 1;
        bit saw_full = 0;
        mem_valid = 1; mem_addr = 9; mem_data = 1;
        for (int i = 0; i < 26; i++) begin
            alu_valid = (i < 6); alu_addr = 9; alu_data = 32'h100 + i;
            tick();
            if (wr_en2) got.push_back(wr_data2);
            if (last_acc_m && mem_valid) begin
                k++;
                if (k > 4) mem_valid = 0; else mem_data = k;
            end
            if (k == 3 && i == 1) begin
                saw_full = 1;
                vectors++;
                if (mem_ready !== 1'b0) begin
                    errs++; $display("FAIL bp_ready got mem_ready=%b exp 0", mem_ready);
                end
            end
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                errs++; $display("FAIL bp_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
            if (got.size() == 4 && !mem_valid && !alu_valid) break;
        end
        mem_valid = 0; alu_valid = 0;
        vectors++;
        if (!saw_full || got.size() != 4) begin
            errs++; $display("FAIL bp_drain got %0d values full_seen=%0d exp 4 values full_seen=1",
                             got.size(), saw_full);
        end else if (got[0] !== 1 || got[1] !== 2 || got[2] !== 3 || got[3] !== 4) begin
            errs++; $display("FAIL bp_order got %0d,%0d,%0d,%0d exp 1,2,3,4", got[0], got[1], got[2], got[3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!alu_valid || last_acc_a) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr = A'($urandom_range(0, 3)); alu_data = $urandom;
            end
            if (!mem_valid || last_acc_m) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_addr = A'($urandom_range(0, 3)); mem_data = $urandom;
            end
            tick();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                errs++; $display("FAIL random cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
            vectors++;
            if (wr_en1 && wr_en2 && wr_addr1 == wr_addr2) begin
                errs++; $display("FAIL same_addr cyc %0d got both ports on %0d exp distinct", cyc, wr_addr1);
            end
        end
        alu_valid = 0; mem_valid = 0;
        repeat (6) tick();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_addr = 2; alu_data = 32'h50 + i;
            mem_valid = 1; mem_addr = 2; mem_data = 32'h60 + i;
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({wr_en1, wr_en2, wr_data1, wr_data2, pend_mask, alu_ready, mem_ready} !==
            {2'b00, {2 * W{1'b0}}, {N{1'b0}}, 2'b11}) begin
            errs++; $display("FAIL mid_reset got en=%b%b d1=%h d2=%h pend=%h rdy=%b%b exp all 0, rdy=11",
                             wr_en1, wr_en2, wr_data1, wr_data2, pend_mask, alu_ready, mem_ready);
        end
        alu_valid = 0; mem_valid = 0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (wr_en1 !== 1'b0 || wr_en2 !== 1'b0 || dut_vec() !== exp_vec()) begin
                errs++; $display("FAIL post_reset cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_single();
        test_parallel();
        test_conflict();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
